systolic_array_ctrl: RTL
========================

# systolic_array_ctrl

Job sequencer for the `Systolic_Array` datapath. It accepts a matrix-multiply job (operand depth `k_len`) and clears the array before each job. It then streams `k_len` A-column/B-row beats into the array under a valid/ready handshake, waits for the array's `valid` with a timeout, captures the `ROWS*COLS` result vector and holds it until the consumer accepts it. It sits between the operand source (buffer or DMA) and the array instance.

## Interface
- `DATA_WIDTH`, 8: operand element width.
- `ROWS`, 8: array rows (elements per A beat).
- `COLS`, 8: array columns (elements per B beat).
- `K_MAX`, 8: maximum job depth.
- `DRAIN_MAX`, 64: cycles allowed in DRAIN before timeout.
- `clk`  in  1  single clock; all logic rising-edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  job request, sampled only in IDLE.
- `k_len`  in  $clog2(K_MAX+1)  job depth, latched with `start`.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  controller accepts a beat.
- `in_A`  in  DATA_WIDTH*ROWS  A column beat.
- `in_B`  in  DATA_WIDTH*COLS  B row beat.
- `arr_rst_n`  out  1  array reset = `rst_n & ~clr_q`.
- `arr_enable`  out  1  array enable.
- `arr_A`  out  DATA_WIDTH*ROWS  array A input.
- `arr_B`  out  DATA_WIDTH*COLS  array B input.
- `arr_valid`  in  1  array result valid.
- `arr_C`  in  2*DATA_WIDTH*ROWS*COLS  array result.
- `res_valid`  out  1  result held for consumer.
- `res_ready`  in  1  consumer accepts result.
- `res_C`  out  2*DATA_WIDTH*ROWS*COLS  captured result.
- `busy`  out  1  state != IDLE.
- `err`  out  1  one-cycle pulse on a rejected start or a timeout.

## Operation
- **Reset values.** All outputs are 0 except `arr_rst_n`. `arr_rst_n` follows `rst_n`, so it is also 0 during reset. State resets to IDLE. The array is reset together with the controller.
- **IDLE.** `start & k_len!=0` latches `k_len`, sets `clr_q` and moves to CLEAR. `start & k_len==0` pulses `err` and stays in IDLE. `k_len > K_MAX` is saturated to K_MAX.
- **CLEAR.** Lasts one cycle. `arr_rst_n` is low for that cycle. Then LOAD with the beat counter at 0.
- **LOAD.** `in_ready` is 1 exactly in this state. A fire is `in_valid & in_ready`.
  - Registered datapath: `arr_enable <= fire`; `arr_A/arr_B <= fire ? in_A/in_B : 0`.
  - Every fire increments the beat counter.
  - The fire that brings the counter to `k_len` moves the state to DRAIN.
  - Non-fire cycles present enable=0 with zero operands (bubbles), so backpressure never corrupts the accumulation.
- **DRAIN.** `arr_enable` is 0 and operands are 0 after the final registered beat. The drain counter counts from 0.
  - First cycle with `arr_valid=1`: `res_C <= arr_C`, go to OUT.
  - Counter reaching DRAIN_MAX-1 without `arr_valid`: pulse `err`, go to IDLE, `res_valid` stays 0.
- **OUT.** `res_valid=1`. `res_C` is stable until `res_ready`. The `res_valid & res_ready` cycle returns the state to IDLE and `res_valid` drops the next cycle.
- `arr_valid` is ignored outside DRAIN.
- `start` is ignored while `busy`.
- `res_C` keeps its last value after the handshake; it is cleared only by reset.

## Timing
- `start` sampled at edge t: CLEAR during cycle t+1, LOAD (`in_ready=1`) from cycle t+2.
- Beat fired at edge e appears on `arr_A/arr_B` with `arr_enable=1` during cycle e+1, giving exactly one cycle of input latency.
- With `in_valid` held high, `in_ready` is high for exactly `k_len` cycles. The array then sees `k_len` consecutive enabled cycles.
- `arr_valid` seen at edge d: `res_valid=1` from cycle d+1.
- Minimum turnaround from `res_ready` handshake to next accepted `start` is 1 cycle (IDLE).
- `rst_n` asserted mid-job, in any state: immediate return to reset values, and the array is reset via `arr_rst_n`. No `err` is raised.
- Simultaneous last fire and `arr_valid` in LOAD: `arr_valid` is ignored.

## Structure
- `systolic_pkg` holds:
  - the state enum (IDLE, CLEAR, LOAD, DRAIN, OUT);
  - `ACC_WIDTH = 2*DATA_WIDTH`;
  - the default ROWS/COLS/K_MAX/DRAIN_MAX values.
- Single module with no sub-module.
- One FSM, one beat counter and one drain counter. The counters share a register, since LOAD and DRAIN are mutually exclusive.

## Test plan
- **Basic job.** ROWS=COLS=8, `k_len=8`, A beats all (1..8), B beats all (1..8), `in_valid` constant. Required: 8 consecutive `arr_enable` cycles, `res_valid` asserted, `res_C[0][0]=8`, `[3][5]=192`, `[7][7]=512`.
- **Input backpressure.** Same data with `in_valid` toggling 1,0,1,0. Required: `arr_enable` high only on cycles after fires, zeros in gaps, identical `res_C`.
- **Output backpressure.** `res_ready` held 0 for 5 cycles after `res_valid`. Required: `res_valid` and `res_C` stable; `busy=1` until the handshake; IDLE the cycle after it.
- **Rejected starts.** `start` with `k_len=0`: one-cycle `err`, `busy` stays 0. `start` pulsed during LOAD: ignored, beat count unchanged.
- **Timeout.** `arr_valid` tied 0, DRAIN_MAX=64. Required: `err` pulse exactly 64 cycles after entering DRAIN, return to IDLE, `res_valid` never 1.
- **Reset mid-job.** `rst_n` low during LOAD after 3 beats. Required: all outputs at reset values, `arr_rst_n=0` while `rst_n` low. A fresh job afterward gives the basic-job result, with no carry-over of the 3 beats.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic array job sequencer.
// No logic: state encoding, accumulator width and default geometry.
// No flow control lives here.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ROWS       = 8;
  localparam int DEF_COLS       = 8;
  localparam int DEF_K_MAX      = 8;
  localparam int DEF_DRAIN_MAX  = 64;

  // Products of two operands need twice the operand width.
  function automatic int acc_width(input int dw);
    return 2 * dw;
  endfunction

  localparam int ACC_WIDTH = acc_width(DEF_DATA_WIDTH);

endpackage

// File: rtl/systolic_array_ctrl.sv
// Job sequencer: clears the array, streams k_len operand beats, captures the result.
// Latency: start -> first in_ready 2 cycles; fired beat -> array input 1 cycle; arr_valid -> res_valid 1 cycle.
// Backpressure: in_valid gaps become enable=0 zero-operand bubbles; res_C is held until res_ready.
module systolic_array_ctrl
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int K_MAX      = DEF_K_MAX,
  parameter int DRAIN_MAX  = DEF_DRAIN_MAX
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  input  logic [$clog2(K_MAX+1)-1:0]                   k_len,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [DATA_WIDTH*ROWS-1:0]                   in_A,
  input  logic [DATA_WIDTH*COLS-1:0]                   in_B,
  output logic                                         arr_rst_n,
  output logic                                         arr_enable,
  output logic [DATA_WIDTH*ROWS-1:0]                   arr_A,
  output logic [DATA_WIDTH*COLS-1:0]                   arr_B,
  input  logic                                         arr_valid,
  input  logic [acc_width(DATA_WIDTH)*ROWS*COLS-1:0]   arr_C,
  output logic                                         res_valid,
  input  logic                                         res_ready,
  output logic [acc_width(DATA_WIDTH)*ROWS*COLS-1:0]   res_C,
  output logic                                         busy,
  output logic                                         err
);

  localparam int KW      = $clog2(K_MAX + 1);
  // One register serves as beat counter (LOAD) and drain timer (DRAIN).
  localparam int CNT_MAX = (DRAIN_MAX > K_MAX) ? DRAIN_MAX : K_MAX + 1;
  localparam int CW      = $clog2(CNT_MAX);

  state_t          state;
  logic [KW-1:0]   k_q;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;
  logic            clr_q;
  logic            fire;

  assign in_ready  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign fire      = in_valid & in_ready;
  assign cnt_inc   = cnt + CW'(1);
  // The array is held in reset with the controller and for the one CLEAR cycle.
  assign arr_rst_n = rst_n & ~clr_q;

  // Job sequencing: state, shared counter, clear strobe, error pulse and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k_q       <= '0;
      cnt       <= '0;
      clr_q     <= 1'b0;
      err       <= 1'b0;
      res_valid <= 1'b0;
      res_C     <= '0;
    end else begin
      err   <= 1'b0;
      clr_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (k_len == '0) begin
              err <= 1'b1;
            end else begin
              k_q   <= (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
              clr_q <= 1'b1;
              state <= CLEAR;
            end
          end
        end
        CLEAR: begin
          cnt   <= '0;
          state <= LOAD;
        end
        LOAD: begin
          if (fire) begin
            if (cnt_inc == CW'(k_q)) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        DRAIN: begin
          if (arr_valid) begin
            res_C     <= arr_C;
            res_valid <= 1'b1;
            state     <= OUT;
          end else if (cnt == CW'(DRAIN_MAX - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand register: only fired beats reach the array; every other cycle is a zero bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_enable <= 1'b0;
      arr_A      <= '0;
      arr_B      <= '0;
    end else begin
      arr_enable <= fire;
      arr_A      <= fire ? in_A : '0;
      arr_B      <= fire ? in_B : '0;
    end
  end

endmodule
